regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32 x 64-bit register file. It shares the single write port (RegWrite / WriteRegister / WriteData) between two writeback requesters, the ALU and the memory/load path, using a valid/ready handshake and round-robin arbitration. It also keeps a busy scoreboard of registers with writes in flight, which decode uses to stall on read-after-write hazards. It sits between the execute/memory stages and the register file's write inputs.

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
//==============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback bus bundle between the two writeback requesters
//               (ALU and memory/load path) and the register file write port.
//               master : requester side (drives valid/reg/data, sees ready and
//                        the registered write port)
//               slave  : arbiter side (grants requests, drives the write port)
// Ports       : alu_valid/alu_reg/alu_data/alu_ready, mem_valid/mem_reg/
//               mem_data/mem_ready, RegWrite/WriteRegister/WriteData
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_wb_if #(
    parameter int DATA_W = 64
);
    logic              alu_valid;
    logic [4:0]        alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [4:0]        mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output RegWrite, WriteRegister, WriteData
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
//==============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between the ALU
//               and the load path with valid/ready handshakes and round-robin
//               arbitration, and keeps a busy scoreboard of registers with
//               writes in flight for decode-stage hazard stalls.
//               Register 31 is the zero register: writes to it are accepted
//               but never reach the register file, and it is never busy.
// Ports       : clk, reset (async, active-low)
//               Reserve, ReserveRegister       - mark a destination busy
//               ReadRegister1/2 -> Busy1/2     - combinational busy lookup
//               wb (slave)                     - requesters and write port
// Macro       : REGFILE_WB_FIXED_PRIO_EN - when defined, MEM always wins on
//               contention and the round-robin pointer is not built.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W = 64
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       Reserve,
    input  wire logic [4:0] ReserveRegister,
    input  wire logic [4:0] ReadRegister1,
    input  wire logic [4:0] ReadRegister2,
    output logic            Busy1,
    output logic            Busy2,
    regfile_wb_if.slave     wb
);

    localparam logic [4:0] c_ZERO_REG = 5'd31;

    logic              grant_alu;
    logic              grant_mem;
    logic              xfer;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              regwrite_q, regwrite_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0]       busy_q, busy_d;

`ifndef REGFILE_WB_FIXED_PRIO_EN
    // 0 = ALU preferred on contention, 1 = MEM preferred
    logic              rr_q, rr_d;
`endif

    // Grant is purely combinational from the valids so ready follows valid
    // even while reset is asserted.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
`ifdef REGFILE_WB_FIXED_PRIO_EN
        grant_mem = wb.mem_valid;
        grant_alu = wb.alu_valid && !wb.mem_valid;
`else
        grant_alu = wb.alu_valid && (!wb.mem_valid || !rr_q);
        grant_mem = wb.mem_valid && (!wb.alu_valid ||  rr_q);
`endif
    end

    assign wb.alu_ready = grant_alu;
    assign wb.mem_ready = grant_mem;

    assign xfer     = grant_alu || grant_mem;
    assign sel_reg  = grant_mem ? wb.mem_reg  : wb.alu_reg;
    assign sel_data = grant_mem ? wb.mem_data : wb.alu_data;

    always_comb begin
        regwrite_d = xfer && (sel_reg != c_ZERO_REG);
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (xfer) begin
            wreg_d  = sel_reg;
            wdata_d = sel_data;
        end

        // Clear first so a same-cycle reserve of the same register wins.
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_reg] = 1'b0;
        end
        if (Reserve && (ReserveRegister != c_ZERO_REG)) begin
            busy_d[ReserveRegister] = 1'b1;
        end
        busy_d[31] = 1'b0;

`ifndef REGFILE_WB_FIXED_PRIO_EN
        // Prefer whoever was not just served.
        rr_d = rr_q;
        if (grant_alu) begin
            rr_d = 1'b1;
        end else if (grant_mem) begin
            rr_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= '0;
            busy_q     <= 32'd0;
`ifndef REGFILE_WB_FIXED_PRIO_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
`ifndef REGFILE_WB_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign wb.RegWrite      = regwrite_q;
    assign wb.WriteRegister = wreg_q;
    assign wb.WriteData     = wdata_q;

    // Registered busy bits only; a clear in this cycle is not bypassed.
    assign Busy1 = busy_q[ReadRegister1];
    assign Busy2 = busy_q[ReadRegister2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//==============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter. Inputs
//               change 1 ns after a rising edge; combinational outputs are
//               checked 1 ns later, registered outputs after the next edge.
//               Honours REGFILE_WB_FIXED_PRIO_EN for the expected grants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 64;

    logic       clk;
    logic       reset;
    logic       Reserve;
    logic [4:0] ReserveRegister;
    logic [4:0] ReadRegister1;
    logic [4:0] ReadRegister2;
    logic       Busy1;
    logic       Busy2;

    int n_cmp;
    int n_fail;

    regfile_wb_if #(.DATA_W(DATA_W)) wb ();

    regfile_wb_arbiter #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .Reserve         (Reserve),
        .ReserveRegister (ReserveRegister),
        .ReadRegister1   (ReadRegister1),
        .ReadRegister2   (ReadRegister2),
        .Busy1           (Busy1),
        .Busy2           (Busy2),
        .wb              (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Reserve         = 1'b0;
        ReserveRegister = 5'd0;
        ReadRegister1   = 5'd0;
        ReadRegister2   = 5'd0;
        wb.alu_valid    = 1'b0;
        wb.alu_reg      = 5'd0;
        wb.alu_data     = '0;
        wb.mem_valid    = 1'b0;
        wb.mem_reg      = 5'd0;
        wb.mem_data     = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        wb.alu_valid = 1'b1;
        wb.alu_reg   = 5'd3;
        wb.alu_data  = 64'h1234;
        #2;
        n_cmp++;
        if (wb.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_alu_ready: got %b want 1", wb.alu_ready);
        end
        step();
        step();
        n_cmp++;
        if (wb.RegWrite !== 1'b0 || wb.WriteRegister !== 5'd0 || wb.WriteData !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_during: got we=%b reg=%0d data=%h want 0/0/0",
                     wb.RegWrite, wb.WriteRegister, wb.WriteData);
        end
        wb.alu_valid = 1'b0;
        reset        = 1'b1;
        step();
        n_cmp++;
        if (wb.RegWrite !== 1'b0 || wb.WriteRegister !== 5'd0 || wb.WriteData !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_after: got we=%b reg=%0d data=%h want 0/0/0",
                     wb.RegWrite, wb.WriteRegister, wb.WriteData);
        end
        for (int r = 0; r < 32; r++) begin
            ReadRegister1 = r[4:0];
            #1;
            n_cmp++;
            if (Busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy[%0d]: got %b want 0", r, Busy1);
            end
        end
        step();
    endtask

    // Reserve 5, ALU writes it back; RegWrite one cycle after the transfer.
    task automatic test_reserve_transfer();
        Reserve         = 1'b1;
        ReserveRegister = 5'd5;
        step();
        Reserve       = 1'b0;
        ReadRegister1 = 5'd5;
        #1;
        n_cmp++;
        if (Busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reserve_busy5: got %b want 1", Busy1);
        end
        wb.alu_valid = 1'b1;
        wb.alu_reg   = 5'd5;
        wb.alu_data  = 64'hDEAD;
        #1;
        n_cmp++;
        if (wb.alu_ready !== 1'b1 || wb.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_alu_ready: got alu=%b mem=%b want 1/0", wb.alu_ready, wb.mem_ready);
        end
        n_cmp++;
        if (wb.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got RegWrite=%b want 0", wb.RegWrite);
        end
        step();
        wb.alu_valid = 1'b0;
        #1;
        n_cmp++;
        if (wb.RegWrite !== 1'b1 || wb.WriteRegister !== 5'd5 || wb.WriteData !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL alu_write: got we=%b reg=%0d data=%h want 1/5/dead",
                     wb.RegWrite, wb.WriteRegister, wb.WriteData);
        end
        n_cmp++;
        if (Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy5_cleared: got %b want 0", Busy1);
        end
        step();
        n_cmp++;
        if (wb.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL write_deassert: got RegWrite=%b want 0", wb.RegWrite);
        end
    endtask

    // Both requesters valid for 4 cycles.
    task automatic test_round_robin();
        logic [3:0] exp_mem_win;
`ifdef REGFILE_WB_FIXED_PRIO_EN
        exp_mem_win = 4'b1111;
`else
        exp_mem_win = 4'b1010;  // bit i = cycle i: ALU, MEM, ALU, MEM
`endif
        // Lone MEM transfer so ALU is preferred next.
        wb.mem_valid = 1'b1;
        wb.mem_reg   = 5'd0;
        wb.mem_data  = 64'h0;
        step();
        wb.alu_valid = 1'b1;
        wb.alu_reg   = 5'd1;
        wb.alu_data  = 64'hA1;
        wb.mem_reg   = 5'd2;
        wb.mem_data  = 64'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (wb.mem_ready !== exp_mem_win[i] || wb.alu_ready !== !exp_mem_win[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got alu=%b mem=%b want alu=%b mem=%b",
                         i, wb.alu_ready, wb.mem_ready, !exp_mem_win[i], exp_mem_win[i]);
            end
            step();
            n_cmp++;
            if (wb.RegWrite !== 1'b1 ||
                wb.WriteRegister !== (exp_mem_win[i] ? 5'd2 : 5'd1) ||
                wb.WriteData !== (exp_mem_win[i] ? 64'hB2 : 64'hA1)) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: got we=%b reg=%0d data=%h", i,
                         wb.RegWrite, wb.WriteRegister, wb.WriteData);
            end
        end
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_reg();
        wb.mem_valid = 1'b1;
        wb.mem_reg   = 5'd31;
        wb.mem_data  = 64'hFFFF;
        #1;
        n_cmp++;
        if (wb.mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reg_ready: got %b want 1", wb.mem_ready);
        end
        step();
        wb.mem_valid = 1'b0;
        n_cmp++;
        if (wb.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_write: got RegWrite=%b want 0", wb.RegWrite);
        end
        Reserve         = 1'b1;
        ReserveRegister = 5'd31;
        step();
        Reserve       = 1'b0;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        #1;
        n_cmp++;
        if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_busy: got %b/%b want 0/0", Busy1, Busy2);
        end
    endtask

    // Same-cycle reserve and clear of reg 7: set wins; later clear works.
    task automatic test_set_wins();
        Reserve         = 1'b1;
        ReserveRegister = 5'd7;
        wb.alu_valid    = 1'b1;
        wb.alu_reg      = 5'd7;
        wb.alu_data     = 64'h77;
        ReadRegister2   = 5'd7;
        #1;
        n_cmp++;
        if (wb.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins_ready: got %b want 1", wb.alu_ready);
        end
        step();
        Reserve      = 1'b0;
        wb.alu_valid = 1'b0;
        #1;
        n_cmp++;
        if (Busy2 !== 1'b1 || wb.RegWrite !== 1'b1 || wb.WriteRegister !== 5'd7) begin
            n_fail++;
            $display("FAIL set_wins: got busy=%b we=%b reg=%0d want 1/1/7",
                     Busy2, wb.RegWrite, wb.WriteRegister);
        end
        wb.alu_valid = 1'b1;
        wb.alu_data  = 64'h78;
        step();
        wb.alu_valid = 1'b0;
        #1;
        n_cmp++;
        if (Busy2 !== 1'b0 || wb.WriteData !== 64'h78) begin
            n_fail++;
            $display("FAIL later_clear: got busy=%b data=%h want 0/78", Busy2, wb.WriteData);
        end
    endtask

    // ALU holds one request while MEM issues three; ALU data written once.
    task automatic test_back_to_back();
        logic [4:0] exp_reg [5];
        logic       exp_we  [5];
        int         mem_sent;
        int         alu_caps;
        logic       alu_pending;
`ifdef REGFILE_WB_FIXED_PRIO_EN
        exp_reg = '{5'd10, 5'd11, 5'd12, 5'd20, 5'd0};
        exp_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        // Previous ALU grant leaves MEM preferred.
        exp_reg = '{5'd10, 5'd20, 5'd11, 5'd12, 5'd0};
        exp_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        mem_sent    = 0;
        alu_caps    = 0;
        alu_pending = 1'b1;
        wb.alu_reg  = 5'd20;
        wb.alu_data = 64'hA20;
        for (int i = 0; i < 5; i++) begin
            logic alu_go;
            logic mem_go;
            wb.alu_valid = alu_pending;
            wb.mem_valid = (mem_sent < 3);
            wb.mem_reg   = 5'(10 + mem_sent);
            wb.mem_data  = 64'(32'h1000 + 10 + mem_sent);
            #1;
            alu_go = wb.alu_ready;
            mem_go = wb.mem_ready;
            step();
            if (mem_go) mem_sent++;
            if (alu_go) alu_pending = 1'b0;
            if (wb.RegWrite === 1'b1 && wb.WriteRegister === 5'd20 && wb.WriteData === 64'hA20)
                alu_caps++;
            n_cmp++;
            if (wb.RegWrite !== exp_we[i] || (exp_we[i] && wb.WriteRegister !== exp_reg[i])) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: got we=%b reg=%0d want we=%b reg=%0d",
                         i, wb.RegWrite, wb.WriteRegister, exp_we[i], exp_reg[i]);
            end
        end
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        n_cmp++;
        if (alu_caps != 1) begin
            n_fail++;
            $display("FAIL b2b_alu_once: got %0d captures want 1", alu_caps);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_reserve_transfer();
        test_round_robin();
        test_zero_reg();
        test_set_wins();
        test_back_to_back();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
